// File: rtl/afu_mem_responder.sv
// afu_mem_responder: host-side memory model for the AFU cache-line request interface.
// Per-channel request FIFOs feed a local line array; reads return after a fixed latency, write acks alternate channels.
module afu_mem_responder #(
    parameter int          ADDR_LMT    = 20,
    parameter int          MDATA       = 14,
    parameter int          CACHE_WIDTH = 512,
    parameter int          MEM_AW      = 6,
    parameter int          FIFO_AW     = 3,
    parameter int          AFULL_SLACK = 2,
    parameter int unsigned RD_LATENCY  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_LMT-1:0]    rd_req_addr,
    input  logic [MDATA-1:0]       rd_req_mdata,
    input  logic                   rd_req_en,
    output logic                   rd_req_almostfull,
    output logic                   rd_rsp_valid,
    output logic [MDATA-1:0]       rd_rsp_mdata,
    output logic [CACHE_WIDTH-1:0] rd_rsp_data,
    input  logic [ADDR_LMT-1:0]    wr_req_addr,
    input  logic [MDATA-1:0]       wr_req_mdata,
    input  logic [CACHE_WIDTH-1:0] wr_req_data,
    input  logic                   wr_req_en,
    output logic                   wr_req_almostfull,
    output logic                   wr_rsp0_valid,
    output logic [MDATA-1:0]       wr_rsp0_mdata,
    output logic                   wr_rsp1_valid,
    output logic [MDATA-1:0]       wr_rsp1_mdata,
    input  logic                   init_we,
    input  logic [MEM_AW-1:0]      init_addr,
    input  logic [CACHE_WIDTH-1:0] init_data,
    output logic [2:0]             err_flags
);
    localparam int               MEM_DEPTH  = 1 << MEM_AW;
    localparam int               FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] AF_CNT     = (FIFO_AW+1)'(FIFO_DEPTH - AFULL_SLACK);
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW+1)'(1);

    logic [CACHE_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_LMT-1:0]    r_rf_addr  [FIFO_DEPTH];
    logic [MDATA-1:0]       r_rf_mdata [FIFO_DEPTH];
    logic [FIFO_AW:0]       r_rf_wp, r_rf_rp;
    logic [ADDR_LMT-1:0]    r_wf_addr  [FIFO_DEPTH];
    logic [MDATA-1:0]       r_wf_mdata [FIFO_DEPTH];
    logic [CACHE_WIDTH-1:0] r_wf_data  [FIFO_DEPTH];
    logic [FIFO_AW:0]       r_wf_wp, r_wf_rp;

    logic                   r_pv [RD_LATENCY];
    logic [MDATA-1:0]       r_pm [RD_LATENCY];
    logic [CACHE_WIDTH-1:0] r_pd [RD_LATENCY];

    logic             r_rd_afull, r_wr_afull;
    logic             r_wr0_valid, r_wr1_valid, r_ack_sel;
    logic [MDATA-1:0] r_wr0_mdata, r_wr1_mdata;
    logic [2:0]       r_err;

    logic [FIFO_AW:0]       w_rf_cnt, w_wf_cnt;
    logic                   w_rf_full, w_wf_full, w_rf_pop, w_wf_pop, w_rf_push, w_wf_push;
    logic [ADDR_LMT-1:0]    w_rd_addr, w_wr_addr;
    logic [MEM_AW-1:0]      w_rd_idx, w_wr_idx;
    logic                   w_rd_oor, w_wr_oor, w_wr_commit;
    logic [MDATA-1:0]       w_rd_mdata, w_wr_mdata;
    logic [CACHE_WIDTH-1:0] w_wr_data, w_rd_data;

    assign w_rf_cnt  = r_rf_wp - r_rf_rp;
    assign w_wf_cnt  = r_wf_wp - r_wf_rp;
    assign w_rf_full = (w_rf_cnt == FULL_CNT);
    assign w_wf_full = (w_wf_cnt == FULL_CNT);
    assign w_rf_pop  = (w_rf_cnt != '0);
    // init_we owns the array port, so the write FIFO holds its head for that cycle
    assign w_wf_pop  = (w_wf_cnt != '0) && !init_we;
    assign w_rf_push = rd_req_en && (!w_rf_full || w_rf_pop);
    assign w_wf_push = wr_req_en && (!w_wf_full || w_wf_pop);

    assign w_rd_addr   = r_rf_addr[r_rf_rp[FIFO_AW-1:0]];
    assign w_rd_mdata  = r_rf_mdata[r_rf_rp[FIFO_AW-1:0]];
    assign w_wr_addr   = r_wf_addr[r_wf_rp[FIFO_AW-1:0]];
    assign w_wr_mdata  = r_wf_mdata[r_wf_rp[FIFO_AW-1:0]];
    assign w_wr_data   = r_wf_data[r_wf_rp[FIFO_AW-1:0]];
    assign w_rd_idx    = w_rd_addr[MEM_AW-1:0];
    assign w_wr_idx    = w_wr_addr[MEM_AW-1:0];
    assign w_rd_oor    = |w_rd_addr[ADDR_LMT-1:MEM_AW];
    assign w_wr_oor    = |w_wr_addr[ADDR_LMT-1:MEM_AW];
    assign w_wr_commit = w_wf_pop && !w_wr_oor;

    // Write-first bypass: same-cycle array writes are visible to the read being popped
    always_comb begin
        w_rd_data = r_mem[w_rd_idx];
        if (w_wr_commit && (w_wr_idx == w_rd_idx))
            w_rd_data = w_wr_data;
        if (init_we && (init_addr == w_rd_idx))
            w_rd_data = init_data;
        if (w_rd_oor)
            w_rd_data = '0;
    end

    always_ff @(posedge clk) begin
        if (init_we)
            r_mem[init_addr] <= init_data;
        else if (w_wr_commit)
            r_mem[w_wr_idx] <= w_wr_data;
        if (w_rf_push) begin
            r_rf_addr[r_rf_wp[FIFO_AW-1:0]]  <= rd_req_addr;
            r_rf_mdata[r_rf_wp[FIFO_AW-1:0]] <= rd_req_mdata;
        end
        if (w_wf_push) begin
            r_wf_addr[r_wf_wp[FIFO_AW-1:0]]  <= wr_req_addr;
            r_wf_mdata[r_wf_wp[FIFO_AW-1:0]] <= wr_req_mdata;
            r_wf_data[r_wf_wp[FIFO_AW-1:0]]  <= wr_req_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_wp     <= '0;
            r_rf_rp     <= '0;
            r_wf_wp     <= '0;
            r_wf_rp     <= '0;
            r_rd_afull  <= 1'b0;
            r_wr_afull  <= 1'b0;
            r_wr0_valid <= 1'b0;
            r_wr1_valid <= 1'b0;
            r_wr0_mdata <= '0;
            r_wr1_mdata <= '0;
            r_ack_sel   <= 1'b0;
            r_err       <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pm[i] <= '0;
                r_pd[i] <= '0;
            end
        end else begin
            if (w_rf_push) r_rf_wp <= r_rf_wp + PTR_ONE;
            if (w_rf_pop)  r_rf_rp <= r_rf_rp + PTR_ONE;
            if (w_wf_push) r_wf_wp <= r_wf_wp + PTR_ONE;
            if (w_wf_pop)  r_wf_rp <= r_wf_rp + PTR_ONE;
            r_rd_afull <= (w_rf_cnt >= AF_CNT);
            r_wr_afull <= (w_wf_cnt >= AF_CNT);

            r_pv[0] <= w_rf_pop;
            if (w_rf_pop) begin
                r_pm[0] <= w_rd_mdata;
                r_pd[0] <= w_rd_data;
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pm[i] <= r_pm[i-1];
                r_pd[i] <= r_pd[i-1];
            end

            r_wr0_valid <= w_wf_pop && !r_ack_sel;
            r_wr1_valid <= w_wf_pop && r_ack_sel;
            if (w_wf_pop) begin
                r_ack_sel <= !r_ack_sel;
                if (r_ack_sel) r_wr1_mdata <= w_wr_mdata;
                else           r_wr0_mdata <= w_wr_mdata;
            end

            if (rd_req_en && w_rf_full && !w_rf_pop) r_err[0] <= 1'b1;
            if (wr_req_en && w_wf_full && !w_wf_pop) r_err[1] <= 1'b1;
            if ((w_rf_pop && w_rd_oor) || (w_wf_pop && w_wr_oor)) r_err[2] <= 1'b1;
        end
    end

    assign rd_req_almostfull = r_rd_afull;
    assign wr_req_almostfull = r_wr_afull;
    assign rd_rsp_valid      = r_pv[RD_LATENCY-1];
    assign rd_rsp_mdata      = r_pm[RD_LATENCY-1];
    assign rd_rsp_data       = r_pd[RD_LATENCY-1];
    assign wr_rsp0_valid     = r_wr0_valid;
    assign wr_rsp0_mdata     = r_wr0_mdata;
    assign wr_rsp1_valid     = r_wr1_valid;
    assign wr_rsp1_mdata     = r_wr1_mdata;
    assign err_flags         = r_err;

endmodule

// File: tb/tb_afu_mem_responder.sv
// Directed scoreboard bench for afu_mem_responder: expectations queued at request time, checked as responses appear.
module tb_afu_mem_responder;
    localparam int RD_LAT = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [19:0]  rd_req_addr = '0;
    logic [13:0]  rd_req_mdata = '0;
    logic         rd_req_en = 1'b0;
    logic         rd_req_almostfull;
    logic         rd_rsp_valid;
    logic [13:0]  rd_rsp_mdata;
    logic [511:0] rd_rsp_data;
    logic [19:0]  wr_req_addr = '0;
    logic [13:0]  wr_req_mdata = '0;
    logic [511:0] wr_req_data = '0;
    logic         wr_req_en = 1'b0;
    logic         wr_req_almostfull;
    logic         wr_rsp0_valid, wr_rsp1_valid;
    logic [13:0]  wr_rsp0_mdata, wr_rsp1_mdata;
    logic         init_we = 1'b0;
    logic [5:0]   init_addr = '0;
    logic [511:0] init_data = '0;
    logic [2:0]   err_flags;

    afu_mem_responder #(.RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
        .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
        .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
        .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0]  m;
        logic [511:0] d;
        int           c;
    } rd_exp_t;

    rd_exp_t      rq[$];
    logic [13:0]  wq[$];
    logic [511:0] tb_mem [64];
    logic         tb_sel = 1'b0;
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk(input int s);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'(s) * 32'h9E37_79B1 + 32'(k);
        return v;
    endfunction

    // Read response and write ack monitor
    always @(negedge clk) begin
        if (rd_rsp_valid) begin
            chk("rd_expected", 512'(rq.size() != 0), 512'd1);
            if (rq.size() != 0) begin
                rd_exp_t e;
                e = rq.pop_front();
                chk("rd_mdata", 512'(rd_rsp_mdata), 512'(e.m));
                chk("rd_data", rd_rsp_data, e.d);
                chk("rd_latency", 512'(cyc), 512'(e.c));
            end
        end
        if (wr_rsp0_valid || wr_rsp1_valid) begin
            chk("wr_both_valid", 512'(wr_rsp0_valid & wr_rsp1_valid), 512'd0);
            chk("wr_expected", 512'(wq.size() != 0), 512'd1);
            if (wq.size() != 0) begin
                logic [13:0] m;
                m = wq.pop_front();
                chk("wr_channel", 512'(wr_rsp1_valid), 512'(tb_sel));
                chk("wr_mdata", 512'(tb_sel ? wr_rsp1_mdata : wr_rsp0_mdata), 512'(m));
                tb_sel = ~tb_sel;
            end
        end
    end

    // Drive one cycle of requests; the model records expectations at drive time (writes before reads).
    task automatic issue(input bit do_wr, input logic [19:0] wa, input logic [13:0] wm,
                         input logic [511:0] wd, input bit wacc,
                         input bit do_rd, input logic [19:0] ra, input logic [13:0] rm);
        rd_exp_t e;
        wr_req_en = do_wr; wr_req_addr = wa; wr_req_mdata = wm; wr_req_data = wd;
        rd_req_en = do_rd; rd_req_addr = ra; rd_req_mdata = rm;
        if (do_wr && wacc) begin
            wq.push_back(wm);
            if (wa[19:6] == '0) tb_mem[wa[5:0]] = wd;
        end
        if (do_rd) begin
            e.m = rm;
            e.d = (ra[19:6] == '0) ? tb_mem[ra[5:0]] : '0;
            e.c = cyc + 1 + RD_LAT;
            rq.push_back(e);
        end
        @(negedge clk);
        wr_req_en = 1'b0;
        rd_req_en = 1'b0;
    endtask

    task automatic rd(input logic [19:0] a, input logic [13:0] m);
        issue(1'b0, '0, '0, '0, 1'b0, 1'b1, a, m);
    endtask

    task automatic wr(input logic [19:0] a, input logic [13:0] m, input logic [511:0] d, input bit acc);
        issue(1'b1, a, m, d, acc, 1'b0, '0, '0);
    endtask

    task automatic preload(input logic [5:0] a, input logic [511:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        tb_mem[a] = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && (rq.size() != 0 || wq.size() != 0); k++) @(negedge clk);
        chk(tag, 512'(rq.size() + wq.size()), 512'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_valid"}, 512'(rd_rsp_valid), 512'd0);
        chk({tag, "_wr_valids"}, 512'({wr_rsp0_valid, wr_rsp1_valid}), 512'd0);
        chk({tag, "_afull"}, 512'({rd_req_almostfull, wr_req_almostfull}), 512'd0);
        chk({tag, "_err"}, 512'(err_flags), 512'd0);
        chk({tag, "_mdata"}, 512'({rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata}), 512'd0);
        chk({tag, "_data"}, rd_rsp_data, 512'd0);
    endtask

    initial begin
        logic [511:0] a5;
        a5 = {64{8'hA5}};
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Preload then read at minimum latency
        preload(6'd5, a5);
        rd(20'd5, 14'h12);
        drain("t1_drain");

        // Back-to-back writes alternate ack channels, then read back
        wr(20'd1, 14'd7, mk(1), 1'b1);
        wr(20'd2, 14'd8, mk(2), 1'b1);
        wr(20'd3, 14'd9, mk(3), 1'b1);
        drain("t2_wr_drain");
        rd(20'd1, 14'd21);
        rd(20'd2, 14'd22);
        rd(20'd3, 14'd23);
        drain("t2_rd_drain");

        // Same-cycle write commit and read of line 9 returns the new data
        preload(6'd9, mk(90));
        issue(1'b1, 20'd9, 14'h2A, mk(91), 1'b1, 1'b1, 20'd9, 14'h2B);
        drain("t4_drain");

        // Continuous read stream keeps order and raises no errors
        for (int i = 0; i < 12; i++) rd(20'((i % 3) + 1), 14'(100 + i));
        drain("t3_rd_burst_drain");
        chk("t3_err", 512'(err_flags), 512'd0);

        // Hold init_we so the write FIFO cannot drain: fill, almostfull, overflow
        init_we = 1'b1; init_addr = 6'd63; init_data = mk(63);
        tb_mem[63] = mk(63);
        for (int i = 0; i < 10; i++) begin
            wr(20'(10 + i), 14'(200 + i), mk(10 + i), i < 8);
            if (i == 3) chk("wr_afull_low_at_4", 512'(wr_req_almostfull), 512'd0);
        end
        chk("wr_afull_high_full", 512'(wr_req_almostfull), 512'd1);
        chk("wr_ovf_flag", 512'(err_flags), 512'b010);
        chk("no_ack_while_stalled", 512'(wq.size()), 512'd8);
        init_we = 1'b0;
        drain("fill_wr_drain");
        chk("wr_afull_low_after", 512'(wr_req_almostfull), 512'd0);
        for (int i = 0; i < 8; i++) rd(20'(10 + i), 14'(300 + i));
        rd(20'd63, 14'h3F);
        drain("fill_rd_drain");

        // Out-of-range read returns zero; out-of-range write acked but discarded
        rd(20'h40, 14'h3FFF);
        wr(20'h41, 14'h55, mk(77), 1'b1);
        rd(20'd1, 14'h56);
        drain("oor_drain");
        chk("oor_flags", 512'(err_flags), 512'b110);

        // Reset in the middle of a read burst
        for (int i = 0; i < 7; i++) rd(20'd2, 14'(400 + i));
        #2 reset_n = 1'b0;
        #1;
        rq.delete();
        wq.delete();
        tb_sel = 1'b0;
        chk_idle("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_quiet", 512'(rq.size() + wq.size()), 512'd0);
        rd(20'd5, 14'h99);
        wr(20'd4, 14'h77, mk(4), 1'b1);
        drain("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end within the time limit");
        $fatal(1, "timeout");
    end

endmodule
